logic_result_stage: RTL and testbench

Registered result stage directly downstream of the 32-bit bitwise logic unit (AND/OR/XOR). It captures each logic result together with its destination tag and computes zero and negative flags at capture time. Results are held in a 2-entry FIFO and presented to writeback through a valid/ready handshake. The stage decouples the combinational logic unit from writeback stalls without losing throughput.

---
 rtl/logic_result_stage.sv | 117 +++++++++++
 tb/tb_logic_result_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_result_stage.sv
// Registered 2-entry result FIFO behind the bitwise logic unit.
// Captures result and tag, computes zero/neg flags at push, and hands off via valid/ready.
module logic_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] retired_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           mem_d [2];
  entry_t           head_q;
  entry_t           head_d;
  entry_t           in_entry;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             rd_q;
  logic             rd_d;
  logic             wr_q;
  logic             wr_d;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic             push;
  logic             pop;

  // Handshake status depends only on the registered occupancy.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_entry = '{result: in_result,
                      tag:    in_tag,
                      zero:   (in_result == '0),
                      neg:    in_result[WIDTH-1]};

  // Next-state: flush wins over push and pop; head register tracks the entry at rd.
  always_comb begin
    mem_d[0]  = mem_q[0];
    mem_d[1]  = mem_q[1];
    count_d   = count_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    retired_d = retired_q;
    head_d    = head_q;
    if (flush) begin
      count_d = 2'd0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_q] = in_entry;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d      = ~rd_q;
        retired_d = retired_q + CNT_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
    if (count_d != 2'd0) begin
      head_d = mem_d[rd_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      head_q    <= '0;
      count_q   <= 2'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      head_q    <= head_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      retired_q <= retired_d;
    end
  end

  assign out_result    = head_q.result;
  assign out_tag       = head_q.tag;
  assign out_zero      = head_q.zero;
  assign out_neg       = head_q.neg;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// Directed self-checking bench for logic_result_stage.
module tb_logic_result_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic        out_neg;
  logic [15:0] retired_count;

  int checks = 0;
  int errors = 0;

  logic_result_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_tag = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_result = 32'h1234_5678; in_tag = 5'd4;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || retired_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_status: valid=%b ready=%b retired=%0d, want 0 1 0",
               out_valid, in_ready, retired_count);
    end
    checks++;
    if (out_result !== 32'd0 || out_tag !== 5'd0 || out_zero !== 1'b0 || out_neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_fields: result=%h tag=%0d zero=%b neg=%b, want all 0",
               out_result, out_tag, out_zero, out_neg);
    end
    rst_n = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'hFFFF_0000; in_tag = 5'd3;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hFFFF_0000 || out_tag !== 5'd3 ||
        out_neg !== 1'b1 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL first_push: valid=%b result=%h tag=%0d neg=%b zero=%b, want 1 ffff0000 3 1 0",
               out_valid, out_result, out_tag, out_neg, out_zero);
    end
  endtask

  task automatic test_zero();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 32'h0; in_tag = 5'd7;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_neg !== 1'b0 || out_tag !== 5'd7) begin
      errors++;
      $display("FAIL zero_flag: valid=%b zero=%b neg=%b tag=%0d, want 1 1 0 7",
               out_valid, out_zero, out_neg, out_tag);
    end
    step();
    checks++;
    if (retired_count !== 16'd1 || out_valid !== 1'b0 || out_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero_pop: retired=%0d valid=%b zero=%b, want 1 0 1",
               retired_count, out_valid, out_zero);
    end
  endtask

  task automatic test_backpressure_full();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd1;
    in_result = 32'h1;
    step();
    in_result = 32'h2;
    step();
    in_result = 32'h3;
    checks++;
    if (in_ready !== 1'b0 || out_result !== 32'h1) begin
      errors++;
      $display("FAIL bp_full: ready=%b result=%h, want 0 00000001", in_ready, out_result);
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || out_result !== 32'h1 || retired_count !== 16'd0) begin
      errors++;
      $display("FAIL bp_hold: ready=%b result=%h retired=%0d, want 0 00000001 0",
               in_ready, out_result, retired_count);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_result !== 32'h2 || retired_count !== 16'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_only: ready=%b result=%h retired=%0d valid=%b, want 1 00000002 1 1",
               in_ready, out_result, retired_count, out_valid);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_result !== 32'h3 || retired_count !== 16'd2 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_same: result=%h retired=%0d valid=%b ready=%b, want 00000003 2 1 1",
               out_result, retired_count, out_valid, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || retired_count !== 16'd3) begin
      errors++;
      $display("FAIL bp_drain: valid=%b retired=%0d, want 0 3", out_valid, retired_count);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_result = 32'd1000 + 32'(i); in_tag = 5'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: ready=%b, want 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd1000 + 32'(i) || out_tag !== 5'(i)) begin
        errors++;
        $display("FAIL stream_data[%0d]: valid=%b result=%0d tag=%0d, want 1 %0d %0d",
                 i, out_valid, out_result, out_tag, 1000 + i, i % 32);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (retired_count !== 16'd100 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_retired: retired=%0d valid=%b, want 100 0", retired_count, out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_result = 32'h10; in_tag = 5'd1;
    step();
    out_ready = 1'b1; in_result = 32'h20; in_tag = 5'd2;
    step();
    out_ready = 1'b0; in_result = 32'h30; in_tag = 5'd3;
    step();
    checks++;
    if (in_ready !== 1'b0 || retired_count !== 16'd1 || out_result !== 32'h20) begin
      errors++;
      $display("FAIL flush_setup: ready=%b retired=%0d result=%h, want 0 1 00000020",
               in_ready, retired_count, out_result);
    end
    flush = 1'b1; out_ready = 1'b1; in_result = 32'h33;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || retired_count !== 16'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: valid=%b retired=%0d ready=%b, want 0 1 1",
               out_valid, retired_count, in_ready);
    end
    in_valid = 1'b1; in_result = 32'h44; in_tag = 5'd4; out_ready = 1'b0;
    step();
    flush = 1'b1; out_ready = 1'b1; in_result = 32'h55;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: ready=%b, want 1", in_ready);
    end
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || retired_count !== 16'd1) begin
      errors++;
      $display("FAIL flush_pushpop: valid=%b retired=%0d, want 0 1", out_valid, retired_count);
    end
    out_ready = 1'b0; in_result = 32'hA5A5_A5A5; in_tag = 5'd9;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hA5A5_A5A5 || out_tag !== 5'd9 ||
        out_neg !== 1'b1 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: valid=%b result=%h tag=%0d neg=%b zero=%b, want 1 a5a5a5a5 9 1 0",
               out_valid, out_result, out_tag, out_neg, out_zero);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_result = 32'h77; in_tag = 5'd5;
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0 || out_tag !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b result=%h tag=%0d, want 0 1 0 0",
               out_valid, in_ready, out_result, out_tag);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_backpressure_full();
    test_streaming();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
